// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32 opcode constants, issue classes and immediate helpers.
package alu_pkg;

  localparam int unsigned Xlen = 32;

  // ALUOp encodings, shared with the ALU
  localparam logic [4:0] AluAdd    = 5'b00000;
  localparam logic [4:0] AluSub    = 5'b00001;
  localparam logic [4:0] AluSeq    = 5'b00010;
  localparam logic [4:0] AluSlt    = 5'b00011;
  localparam logic [4:0] AluSltu   = 5'b00111;
  localparam logic [4:0] AluAnd    = 5'b01100;
  localparam logic [4:0] AluOr     = 5'b01110;
  localparam logic [4:0] AluXor    = 5'b10000;
  localparam logic [4:0] AluSll    = 5'b10010;
  localparam logic [4:0] AluSrl    = 5'b10011;
  localparam logic [4:0] AluSra    = 5'b10101;
  localparam logic [4:0] AluMul    = 5'b10110;
  localparam logic [4:0] AluMulh   = 5'b10111;
  localparam logic [4:0] AluMulhu  = 5'b11000;
  localparam logic [4:0] AluMulhsu = 5'b11001;
  localparam logic [4:0] AluDiv    = 5'b11010;
  localparam logic [4:0] AluDivu   = 5'b11011;
  localparam logic [4:0] AluRem    = 5'b11100;
  localparam logic [4:0] AluRemu   = 5'b11101;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [2:0] {
    ClsAlu     = 3'd0,
    ClsLoad    = 3'd1,
    ClsStore   = 3'd2,
    ClsBranch  = 3'd3,
    ClsIllegal = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    ImmI,
    ImmS,
    ImmU,
    ImmShamt
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]      op;
    logic [Xlen-1:0] a;
    logic [Xlen-1:0] b;
    logic [Xlen-1:0] store_data;
    logic [4:0]      rd;
    logic            rd_we;
    cls_e            cls;
    logic            br_inv;
  } issue_t;

  function automatic logic [Xlen-1:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [Xlen-1:0] imm;
    unique case (fmt)
      ImmI:     imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmU:     imm = {instr[31:12], 12'b0};
      ImmShamt: imm = {27'b0, instr[24:20]};
      default:  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32IM decode into ALUOp, operands, destination and issue class.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [Xlen-1:0] pc_i,
  input  logic [Xlen-1:0] rs1_i,
  input  logic [Xlen-1:0] rs2_i,
  output logic [4:0]      op_o,
  output logic [Xlen-1:0] a_o,
  output logic [Xlen-1:0] b_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output cls_e            cls_o,
  output logic            br_inv_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    op_o     = AluAdd;
    a_o      = '0;
    b_o      = '0;
    rd_o     = instr_i[11:7];
    rd_we_o  = 1'b0;
    cls_o    = ClsAlu;
    br_inv_o = 1'b0;
    illegal  = 1'b0;

    unique case (opcode)
      OpcOp: begin
        a_o     = rs1_i;
        b_o     = rs2_i;
        rd_we_o = 1'b1;
        unique case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'd0:    op_o = AluAdd;
              3'd1:    op_o = AluSll;
              3'd2:    op_o = AluSlt;
              3'd3:    op_o = AluSltu;
              3'd4:    op_o = AluXor;
              3'd5:    op_o = AluSrl;
              3'd6:    op_o = AluOr;
              default: op_o = AluAnd;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'd0)      op_o = AluSub;
            else if (funct3 == 3'd5) op_o = AluSra;
            else                     illegal = 1'b1;
          end
          7'b0000001: begin
            unique case (funct3)
              3'd0:    op_o = AluMul;
              3'd1:    op_o = AluMulh;
              3'd2:    op_o = AluMulhsu;
              3'd3:    op_o = AluMulhu;
              3'd4:    op_o = AluDiv;
              3'd5:    op_o = AluDivu;
              3'd6:    op_o = AluRem;
              default: op_o = AluRemu;
            endcase
          end
          default: illegal = 1'b1;
        endcase
        // The ALU shifts by the whole B value, so only the low five bits may pass
        if (op_o == AluSll || op_o == AluSrl || op_o == AluSra) begin
          b_o = {27'b0, rs2_i[4:0]};
        end
      end
      OpcOpImm: begin
        a_o     = rs1_i;
        b_o     = imm_gen(instr_i, ImmI);
        rd_we_o = 1'b1;
        unique case (funct3)
          3'd0: op_o = AluAdd;
          3'd1: begin
            op_o    = AluSll;
            b_o     = imm_gen(instr_i, ImmShamt);
            illegal = (funct7 != 7'b0000000);
          end
          3'd2: op_o = AluSlt;
          3'd3: op_o = AluSltu;
          3'd4: op_o = AluXor;
          3'd5: begin
            b_o = imm_gen(instr_i, ImmShamt);
            if (funct7 == 7'b0000000)      op_o = AluSrl;
            else if (funct7 == 7'b0100000) op_o = AluSra;
            else                           illegal = 1'b1;
          end
          3'd6:    op_o = AluOr;
          default: op_o = AluAnd;
        endcase
      end
      OpcLui: begin
        b_o     = imm_gen(instr_i, ImmU);
        rd_we_o = 1'b1;
      end
      OpcAuipc: begin
        a_o     = pc_i;
        b_o     = imm_gen(instr_i, ImmU);
        rd_we_o = 1'b1;
      end
      OpcLoad: begin
        a_o     = rs1_i;
        b_o     = imm_gen(instr_i, ImmI);
        cls_o   = ClsLoad;
        rd_we_o = 1'b1;
        illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OpcStore: begin
        a_o     = rs1_i;
        b_o     = imm_gen(instr_i, ImmS);
        cls_o   = ClsStore;
        illegal = (funct3 > 3'd2);
      end
      OpcBranch: begin
        a_o   = rs1_i;
        b_o   = rs2_i;
        cls_o = ClsBranch;
        unique case (funct3)
          3'd0:    op_o = AluSeq;
          3'd1:    begin op_o = AluSeq;  br_inv_o = 1'b1; end
          3'd4:    op_o = AluSlt;
          3'd5:    begin op_o = AluSlt;  br_inv_o = 1'b1; end
          3'd6:    op_o = AluSltu;
          3'd7:    begin op_o = AluSltu; br_inv_o = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      op_o     = AluAdd;
      a_o      = '0;
      b_o      = '0;
      rd_we_o  = 1'b0;
      cls_o    = ClsIllegal;
      br_inv_o = 1'b0;
    end

    // No architectural destination: report rd as x0 with writeback off
    if (!rd_we_o || rd_o == 5'd0) begin
      rd_o    = 5'd0;
      rd_we_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry issue register between decode and the ALU, with valid/ready handshake and flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_rs1_data_i,
  input  logic [XLEN-1:0] in_rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0]      out_alu_op_o,
  output logic [XLEN-1:0] out_a_o,
  output logic [XLEN-1:0] out_b_o,
  output logic [XLEN-1:0] out_store_data_o,
  output logic [4:0]      out_rd_o,
  output logic            out_rd_we_o,
  output logic [2:0]      out_cls_o,
  output logic            out_br_inv_o,
  output logic [XLEN-1:0] out_pc_o
);

  issue_t          dec;
  issue_t          data_d, data_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            valid_d, valid_q;
  logic            accept;

  alu_op_decode u_decode (
    .instr_i  (in_instr_i),
    .pc_i     (in_pc_i),
    .rs1_i    (in_rs1_data_i),
    .rs2_i    (in_rs2_data_i),
    .op_o     (dec.op),
    .a_o      (dec.a),
    .b_o      (dec.b),
    .rd_o     (dec.rd),
    .rd_we_o  (dec.rd_we),
    .cls_o    (dec.cls),
    .br_inv_o (dec.br_inv)
  );
  assign dec.store_data = in_rs2_data_i;

  assign in_ready_o = ~valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (in_ready_o) valid_d = in_valid_i;
    if (flush_i)    valid_d = 1'b0;
    if (accept) begin
      data_d = dec;
      pc_d   = in_pc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= RESET_PC_TAG;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid_o      = valid_q;
  assign out_alu_op_o     = data_q.op;
  assign out_a_o          = data_q.a;
  assign out_b_o          = data_q.b;
  assign out_store_data_o = data_q.store_data;
  assign out_rd_o         = data_q.rd;
  assign out_rd_we_o      = data_q.rd_we;
  assign out_cls_o        = data_q.cls;
  assign out_br_inv_o     = data_q.br_inv;
  assign out_pc_o         = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, flush and async reset.
module tb_alu_issue_stage;

  localparam logic [31:0] RstPc = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_alu_op;
  logic [31:0] out_a, out_b, out_store_data, out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [2:0]  out_cls;
  logic        out_br_inv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(
    .XLEN         (32),
    .RESET_PC_TAG (RstPc)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_instr_i       (in_instr),
    .in_pc_i          (in_pc),
    .in_rs1_data_i    (in_rs1),
    .in_rs2_data_i    (in_rs2),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_alu_op_o     (out_alu_op),
    .out_a_o          (out_a),
    .out_b_o          (out_b),
    .out_store_data_o (out_store_data),
    .out_rd_o         (out_rd),
    .out_rd_we_o      (out_rd_we),
    .out_cls_o        (out_cls),
    .out_br_inv_o     (out_br_inv),
    .out_pc_o         (out_pc)
  );

  // Packed view: valid, op, a, b, rd, rd_we, cls, br_inv
  function automatic logic [79:0] obs();
    return {out_valid, out_alu_op, out_a, out_b, out_rd, out_rd_we, out_cls, out_br_inv};
  endfunction

  function automatic logic [79:0] ev(input logic v, input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] rd, input logic we,
                                     input logic [2:0] cls, input logic inv);
    return {v, op, a, b, rd, we, cls, inv};
  endfunction

  // Present one instruction for a single edge, then sample 1 time unit later
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [79:0] e;
    e = ev(0, 5'b00000, 32'h0, 32'h0, 5'd0, 0, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset_outs: got %h want %h", obs(), e); end
    total++;
    if (out_pc !== RstPc || out_store_data !== 32'h0) begin
      bad++; $display("FAIL reset_pc: got pc=%h sd=%h want pc=%h sd=0", out_pc, out_store_data, RstPc);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu_ops();
    logic [79:0] e;
    drive(32'h002081B3, 32'h100, 32'd5, 32'd7);             // add x3,x1,x2
    e = ev(1, 5'b00000, 32'd5, 32'd7, 5'd3, 1, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL add: got %h want %h", obs(), e); end
    drive(32'h40335293, 32'h104, 32'h8000_0000, 32'h55);    // srai x5,x6,3
    e = ev(1, 5'b10101, 32'h8000_0000, 32'd3, 5'd5, 1, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL srai: got %h want %h", obs(), e); end
    drive(32'h023110B3, 32'h108, 32'h11, 32'h22);           // mulh x1,x2,x3
    e = ev(1, 5'b10111, 32'h11, 32'h22, 5'd1, 1, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL mulh: got %h want %h", obs(), e); end
    drive(32'h002091B3, 32'h10C, 32'h1, 32'h123);           // sll x3,x1,x2
    e = ev(1, 5'b10010, 32'h1, 32'h3, 5'd3, 1, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL sll_mask: got %h want %h", obs(), e); end
    drive(32'hFFF08213, 32'h110, 32'h10, 32'h0);            // addi x4,x1,-1
    e = ev(1, 5'b00000, 32'h10, 32'hFFFF_FFFF, 5'd4, 1, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL addi_neg: got %h want %h", obs(), e); end
    drive(32'h00208033, 32'h114, 32'd5, 32'd7);             // add x0,x1,x2
    e = ev(1, 5'b00000, 32'd5, 32'd7, 5'd0, 0, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rd_x0: got %h want %h", obs(), e); end
  endtask

  task automatic test_upper();
    logic [79:0] e;
    drive(32'h123453B7, 32'h200, 32'h77, 32'h88);           // lui x7,0x12345
    e = ev(1, 5'b00000, 32'h0, 32'h1234_5000, 5'd7, 1, 3'd0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL lui: got %h want %h", obs(), e); end
    drive(32'h00001297, 32'h1000_0040, 32'h77, 32'h88);     // auipc x5,0x1
    e = ev(1, 5'b00000, 32'h1000_0040, 32'h0000_1000, 5'd5, 1, 3'd0, 0);
    total++;
    if (obs() !== e || out_pc !== 32'h1000_0040) begin
      bad++; $display("FAIL auipc: got %h pc=%h want %h pc=10000040", obs(), out_pc, e);
    end
  endtask

  task automatic test_mem();
    logic [79:0] e;
    drive(32'hFFC0A303, 32'h300, 32'h2000, 32'h0);          // lw x6,-4(x1)
    e = ev(1, 5'b00000, 32'h2000, 32'hFFFF_FFFC, 5'd6, 1, 3'd1, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL load: got %h want %h", obs(), e); end
    drive(32'h0020A623, 32'h304, 32'h3000, 32'hCAFE_BABE);  // sw x2,12(x1)
    e = ev(1, 5'b00000, 32'h3000, 32'hC, 5'd0, 0, 3'd2, 0);
    total++;
    if (obs() !== e || out_store_data !== 32'hCAFE_BABE) begin
      bad++; $display("FAIL store: got %h sd=%h want %h sd=cafebabe", obs(), out_store_data, e);
    end
  endtask

  task automatic test_branch();
    logic [79:0] e;
    drive(32'h00209463, 32'h400, 32'd10, 32'd20);           // bne
    e = ev(1, 5'b00010, 32'd10, 32'd20, 5'd0, 0, 3'd3, 1);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL bne: got %h want %h", obs(), e); end
    drive(32'h0020C463, 32'h404, 32'd10, 32'd20);           // blt
    e = ev(1, 5'b00011, 32'd10, 32'd20, 5'd0, 0, 3'd3, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL blt: got %h want %h", obs(), e); end
    drive(32'h0020F463, 32'h408, 32'd10, 32'd20);           // bgeu
    e = ev(1, 5'b00111, 32'd10, 32'd20, 5'd0, 0, 3'd3, 1);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL bgeu: got %h want %h", obs(), e); end
  endtask

  task automatic test_illegal();
    logic [79:0] e;
    e = ev(1, 5'b00000, 32'h0, 32'h0, 5'd0, 0, 3'd4, 0);
    drive(32'hFFFF_FFFF, 32'h500, 32'h1, 32'h2);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL ill_all_ones: got %h want %h", obs(), e); end
    drive(32'h40209133, 32'h504, 32'h1, 32'h2);             // funct7 0100000 funct3 1
    total++;
    if (obs() !== e) begin bad++; $display("FAIL ill_funct7: got %h want %h", obs(), e); end
    drive(32'h0020A463, 32'h508, 32'h1, 32'h2);             // branch funct3 2
    total++;
    if (obs() !== e) begin bad++; $display("FAIL ill_branch_f3: got %h want %h", obs(), e); end
  endtask

  task automatic test_backpressure();
    logic [79:0] e_add, e_sub;
    e_add = ev(1, 5'b00000, 32'd5, 32'd7, 5'd3, 1, 3'd0, 0);
    e_sub = ev(1, 5'b00001, 32'd9, 32'd4, 5'd3, 1, 3'd0, 0);
    drive(32'h002081B3, 32'h600, 32'd5, 32'd7);
    out_ready = 1'b0;
    in_instr  = 32'h402081B3;                               // sub x3,x1,x2
    in_rs1    = 32'd9;
    in_rs2    = 32'd4;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0 || obs() !== e_add) begin
        bad++; $display("FAIL bp_hold%0d: got rdy=%b %h want rdy=0 %h", i, in_ready, obs(), e_add);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (obs() !== e_sub) begin bad++; $display("FAIL bp_next: got %h want %h", obs(), e_sub); end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [79:0] e;
    drive(32'h002081B3, 32'h700, 32'd1, 32'd2);
    drive(32'h023110B3, 32'h704, 32'd3, 32'd4);
    e = ev(1, 5'b10111, 32'd3, 32'd4, 5'd1, 1, 3'd0, 0);
    total++;
    if (obs() !== e || out_pc !== 32'h704) begin
      bad++; $display("FAIL b2b: got %h pc=%h want %h pc=704", obs(), out_pc, e);
    end
  endtask

  task automatic test_flush();
    drive(32'h002081B3, 32'h800, 32'd5, 32'd7);
    in_instr = 32'h123453B7;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [79:0] e;
    e = ev(0, 5'b00000, 32'h0, 32'h0, 5'd0, 0, 3'd0, 0);
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h900, 32'd5, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs() !== e || out_pc !== RstPc || out_store_data !== 32'h0) begin
      bad++; $display("FAIL async_reset: got %h pc=%h want %h pc=%h", obs(), out_pc, e, RstPc);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL no_replay: got %b want 0", out_valid); end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_alu_ops();
    test_upper();
    test_mem();
    test_branch();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the 32-bit ALU's operation interface: A, B and the 5-bit ALUOp.
- Takes a fetched RV32IM instruction plus register-file read data. Decodes the ALUOp, selects the operands, and registers the result into a one-entry pipeline stage with a valid/ready handshake towards execute.
- Sits between the register file and the ALU in the core pipeline.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RESET_PC_TAG, 0, value driven on out_pc at reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  instruction/operands valid.
- in_ready  output  1  stage can accept.
- in_instr  input  32  instruction word.
- in_pc  input  32  instruction PC.
- in_rs1_data  input  32  register rs1 value.
- in_rs2_data  input  32  register rs2 value.
- out_valid  output  1  issued op valid.
- out_ready  input  1  execute accepts.
- out_alu_op  output  5  ALUOp code to the ALU.
- out_a  output  32  ALU operand A.
- out_b  output  32  ALU operand B.
- out_store_data  output  32  rs2 value for stores.
- out_rd  output  5  destination register.
- out_rd_we  output  1  writeback enable.
- out_cls  output  3  class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 ILLEGAL.
- out_br_inv  output  1  invert branch compare result (BNE/BGE/BGEU).
- out_pc  output  32  registered PC.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0 and out_alu_op=0.
  - out_a, out_b, out_store_data, out_rd, out_rd_we, out_cls and out_br_inv all =0.
  - out_pc=RESET_PC_TAG.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - Latency is 1 cycle; full throughput when out_ready=1.
  - While out_valid=1 and out_ready=0, all out_* hold stable.
- Flush:
  - On the next edge out_valid=0.
  - An input presented in the same cycle is dropped; flush wins over in_valid.
  - Data registers may hold stale values.
- ALUOp encodings:
  - ADD 00000, SUB 00001, SEQ 00010, SLT 00011, SLTU 00111.
  - AND 01100, OR 01110, XOR 10000.
  - SLL 10010, SRL 10011, SRA 10101.
  - MUL 10110, MULH 10111, MULHU 11000, MULHSU 11001.
  - DIV 11010, DIVU 11011, REM 11100, REMU 11101.
- OP (0110011), A=rs1, B=rs2, rd_we=1:
  - funct7 0000000: funct3 0..7 map to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000: only SUB (f3=0) and SRA (f3=5).
  - funct7 0000001: funct3 maps to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
  - Shifts: B={27'b0, rs2[4:0]}, because the ALU shifts by the full B value.
- OP-IMM (0010011): A=rs1, B=sign-extended imm[11:0].
  - Shift immediates: B={27'b0, shamt}.
  - SLLI/SRLI require imm[11:5]=0000000; SRAI requires 0100000.
- LUI: A=0, B={imm[31:12], 12'b0}, op ADD.
- AUIPC: A=pc, B=U-imm, op ADD.
- LOAD (0000011): op ADD, A=rs1, B=I-imm, cls=1, rd_we=1.
- STORE (0100011): op ADD, A=rs1, B=S-imm, cls=2, rd_we=0, store_data=rs2.
- BRANCH (1100011): A=rs1, B=rs2, cls=3, rd_we=0.
  - BEQ/BNE use SEQ; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - br_inv=1 for BNE, BGE and BGEU.
- Illegal decode: any other opcode, reserved funct3/funct7, or branch funct3 2/3.
  - cls=4, op ADD, rd_we=0, A=B=0. Still handshaked through normally.
- rd=x0: out_rd=0 and out_rd_we forced to 0.
- Reset mid-handshake: the pending output is discarded and nothing is replayed.

Decomposition:
- Package alu_pkg holds:
  - ALUOp localparams, shared with the ALU.
  - Opcode constants.
  - Class codes.
  - Immediate-format constants.
- Sub-module alu_op_decode: purely combinational. Maps instr, pc, rs1, rs2 to op, a, b, rd, rd_we, cls, br_inv.
- alu_issue_stage instantiates alu_op_decode and adds the handshake register and flush logic.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, alu_op=00000, a=5, b=7, rd=3, rd_we=1, cls=0.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> alu_op=10101, b=3, rd=5. MULH x1,x2,x3 (0x023110B3) -> alu_op=10111.
- LUI x7,0x12345 (0x123453B7) -> a=0, b=0x12345000, op ADD. BNE (funct3=001) -> op SEQ, br_inv=1, rd_we=0, cls=3.
- Illegal 0xFFFFFFFF -> cls=4, rd_we=0. OP with funct7=0100000, funct3=001 -> cls=4.
- Backpressure: issue ADD, hold out_ready=0 for 3 cycles -> in_ready=0 and outputs stable. Release -> one transfer, the next op follows with no bubble.
- Flush with in_valid=1 -> out_valid=0 next cycle. Assert rst while out_valid=1 -> out_valid=0 immediately (async), all outputs at reset values.
